kern_burst_reader: RTL and testbench
====================================

// Module: kern_burst_reader
// PURPOSE
//  Parametrised successor to the CCM kernel fetch unit. Streams kernel weights plus per-kernel
//  biases from external memory to the MAC array. Memory words are unpacked into ELEM_W-bit
//  elements through an internal FIFO. Bursts are prefetched while earlier data drains, and
//  the output honours consumer backpressure (kern_rdy).
//  Sits between the CCM memory arbiter port and the kernel register bank.
// PARAMETERS
//  MEM_DW      32  memory data width; must be an integer multiple R of ELEM_W
//  ELEM_W      16  output element width
//  ADDR_W      32  byte address width
//  MAX_BURST   16  max words per memory burst (power of 2, <=16)
//  FIFO_WORDS  32  FIFO capacity in memory words (>= 2*MAX_BURST)
// PORTS
//  clk                 in   1       clock
//  rst_n               in   1       async active-low reset
//  op_start            in   1       start pulse; ignored while busy
//  cfg_kern_start_addr in   ADDR_W  byte base address, sampled on op_start
//  cfg_num_fmap        in   10      input channels, sampled on op_start
//  cfg_num_kern        in   10      kernel sets, sampled on op_start
//  cfg_kern_size       in   3       kernel edge K (1..7), sampled on op_start
//  busy                out  1       high from cycle after op_start until done
//  done                out  1       1-cycle pulse when last element is accepted
//  ccm_req             out  1       arbiter request
//  mem_grant           in   1       arbiter grant to this block
//  mem_addr            out  ADDR_W  burst byte address
//  mem_cmd             out  4       burst length minus 1 (in words), valid while ccm_req
//  mem_din             in   MEM_DW  read data
//  mem_vld             in   1       mem_din valid this cycle
//  mem_fin             in   1       final word of burst (coincides with its mem_vld)
//  kern_out            out  ELEM_W  element
//  kern_vld            out  1       kern_out valid
//  kern_rdy            in   1       consumer accepts when kern_vld&kern_rdy
// BEHAVIOUR
//  - Reset: busy=0, done=0, ccm_req=0, mem_cmd=0, mem_addr=0, kern_vld=0, kern_out=0.
//    FIFO is emptied; FSM goes to IDLE; all counters are cleared.
//    Reset mid-operation aborts immediately; there is no memory-side cleanup.
//  - On op_start in IDLE, the block latches the config and computes (24-bit, saturating, no wrap):
//    elems = fmap*kern*K*K + kern; words = ceil(elems/R).
//  - FSM: IDLE -> CALC -> REQ -> DATA -> (CALC | WAIT_DRAIN) -> IDLE.
//  - CALC: blen = min(words_left, MAX_BURST); words_left -= blen.
//    If elems==0, go straight to WAIT_DRAIN.
//  - REQ:
//    - ccm_req asserts only when FIFO free words >= blen.
//    - mem_cmd = blen-1; mem_addr = current address.
//    - Hold until mem_grant; the arbiter may grant in the same cycle as the request.
//  - DATA:
//    - ccm_req=0 from the cycle after grant.
//    - Each mem_vld pushes mem_din into the FIFO.
//    - mem_fin with mem_vld: address += blen*(MEM_DW/8); go to CALC if words_left>0, else WAIT_DRAIN.
//    - mem_vld never overflows the FIFO, because space was reserved in REQ.
//  - Output path runs concurrently with all states:
//    - kern_vld = FIFO non-empty and emitted < elems.
//    - Unpack order: element 0 = mem_din[ELEM_W-1:0], then ascending slices.
//    - The word pops after its R-th element is accepted.
//    - kern_out and kern_vld hold stable while kern_vld&~kern_rdy.
//  - Final word: pad slices beyond elems are never presented; that word is discarded after
//    the last real element.
//  - WAIT_DRAIN: when the last element is accepted, done pulses for one cycle, busy drops in
//    the same cycle, and the FSM returns to IDLE.
//  - Simultaneous push and pop on the same cycle is legal; the count stays constant.
//  - op_start while busy is ignored, and config changes while busy have no effect.
//  - Latency: first kern_vld is no earlier than 1 cycle after the first mem_vld.
//  - Throughput: 1 element/cycle with kern_rdy held high.
// TESTING
//  - fmap=1, kern=1, K=3, rdy=1:
//    elems=10, words=5, one burst with mem_cmd=4.
//    10 elements in order, low half first.
//    done exactly 1 cycle after the 10th handshake.
//  - fmap=4, kern=8, K=3: elems=296, words=148.
//    Expect 10 bursts (9x16 + 1x4) at addresses base+0, +64, ... +576.
//  - Odd total (fmap=1, kern=1, K=1): elems=2, words=1.
//    fmap=1, kern=3, K=1: elems=6, words=3.
//    fmap=1, kern=1, K=2: elems=5, words=3; upper half of word 2 is never emitted.
//  - kern_rdy toggled randomly with ~10% duty:
//    no element lost or duplicated, kern_out stable while stalled.
//    ccm_req is withheld whenever FIFO free < 16.
//  - Grant delayed 20 cycles, then same-cycle grant: each burst is issued exactly once.
//    Reset asserted mid-DATA: all outputs return to reset values, and a new op_start
//    runs cleanly afterwards.

Source files
------------

// File: rtl/kern_burst_reader.sv
// kern_burst_reader
//   Streams kernel weights and per-kernel biases from external memory to the
//   MAC array. Bursts of up to MAX_BURST words are fetched through the CCM
//   arbiter into a word FIFO. Each word is unpacked into R = MEM_DW/ELEM_W
//   elements, lowest slice first. The next burst is prefetched while earlier
//   data drains.
// Ports
//   clk, rst_n             clock, async active-low reset
//   op_start               start pulse (ignored while busy)
//   cfg_*                  base address, fmap/kern counts, kernel edge; sampled on op_start
//   busy, done             operation in progress / 1-cycle completion pulse
//   ccm_req, mem_grant     arbiter handshake
//   mem_addr, mem_cmd      burst byte address / burst length minus 1
//   mem_din, mem_vld,
//   mem_fin                read data, data valid, last word of burst
//   kern_out, kern_vld,
//   kern_rdy               element stream with consumer backpressure
module kern_burst_reader #(
   parameter int unsigned MEM_DW     = 32,
   parameter int unsigned ELEM_W     = 16,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned FIFO_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_start,
   input  logic [ADDR_W-1:0] cfg_kern_start_addr,
   input  logic [9:0]        cfg_num_fmap,
   input  logic [9:0]        cfg_num_kern,
   input  logic [2:0]        cfg_kern_size,
   output logic              busy,
   output logic              done,
   output logic              ccm_req,
   input  logic              mem_grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_cmd,
   input  logic [MEM_DW-1:0] mem_din,
   input  logic              mem_vld,
   input  logic              mem_fin,
   output logic [ELEM_W-1:0] kern_out,
   output logic              kern_vld,
   input  logic              kern_rdy
);

   localparam int unsigned R      = MEM_DW / ELEM_W;
   localparam int unsigned SL_W   = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned PTR_W  = (FIFO_WORDS > 1) ? $clog2(FIFO_WORDS) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_WORDS + 1);
   localparam int unsigned BLEN_W = $clog2(MAX_BURST + 1);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(MEM_DW / 8);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_CALC       = 3'd1;
   localparam logic [2:0] ST_REQ        = 3'd2;
   localparam logic [2:0] ST_DATA       = 3'd3;
   localparam logic [2:0] ST_WAIT_DRAIN = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [23:0]       elems_q, elems_d;
   logic [23:0]       words_left_q, words_left_d;
   logic [23:0]       emitted_q, emitted_d;
   logic [BLEN_W-1:0] blen_q, blen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SL_W-1:0]   slice_q, slice_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q, done_d;

   logic [MEM_DW-1:0] fifo_mem [FIFO_WORDS];

   logic [31:0]       prod;
   logic [23:0]       start_elems;
   logic [23:0]       start_words;
   logic [BLEN_W-1:0] blen_calc;
   logic [CNT_W-1:0]  free_words;
   logic              req_ok;
   logic [MEM_DW-1:0] head_word;
   logic [ELEM_W-1:0] head_elem;
   logic              vld;
   logic              accept;
   logic              last_elem;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_WORDS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Element/word totals for the configuration on the inputs. The product is
   // formed at 32 bits so it can be saturated to 24 bits instead of wrapping.
   always_comb begin
      prod = 32'(cfg_num_fmap) * 32'(cfg_num_kern) * 32'(cfg_kern_size) * 32'(cfg_kern_size)
             + 32'(cfg_num_kern);
      start_elems = (|prod[31:24]) ? '1 : prod[23:0];
      start_words = (start_elems / 24'(R)) + 24'((start_elems % 24'(R)) != 24'd0);
   end

   always_comb begin
      blen_calc  = (words_left_q >= 24'(MAX_BURST)) ? BLEN_W'(MAX_BURST)
                                                     : words_left_q[BLEN_W-1:0];
      free_words = CNT_W'(FIFO_WORDS) - count_q;
      req_ok     = (free_words >= CNT_W'(blen_q));
   end

   // Output unpacking: slice_q selects the element within the head word.
   always_comb begin
      head_word = fifo_mem[rd_ptr_q];
      head_elem = '0;
      for (int unsigned i = 0; i < R; i++) begin
         if (slice_q == SL_W'(i)) head_elem = head_word[i*ELEM_W +: ELEM_W];
      end
      vld       = (count_q != '0) && (emitted_q < elems_q);
      accept    = vld && kern_rdy;
      last_elem = (emitted_q == (elems_q - 24'd1));
      // A word leaves the FIFO after its last slice, or after the final real
      // element so the padding slices of the last word are dropped unseen.
      pop       = accept && ((slice_q == SL_W'(R - 1)) || last_elem);
      push      = (state_q == ST_DATA) && mem_vld;
   end

   always_comb begin
      state_d      = state_q;
      elems_d      = elems_q;
      words_left_d = words_left_q;
      emitted_d    = emitted_q;
      blen_d       = blen_q;
      addr_d       = addr_q;
      slice_d      = slice_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      done_d       = 1'b0;

      if (accept) begin
         emitted_d = emitted_q + 24'd1;
         slice_d   = pop ? '0 : slice_q + SL_W'(1);
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
         ST_IDLE: begin
            if (op_start) begin
               elems_d      = start_elems;
               words_left_d = start_words;
               emitted_d    = '0;
               addr_d       = cfg_kern_start_addr;
               state_d      = ST_CALC;
            end
         end
         ST_CALC: begin
            if (elems_q == '0) begin
               state_d = ST_WAIT_DRAIN;
            end else begin
               blen_d       = blen_calc;
               words_left_d = words_left_q - 24'(blen_calc);
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (req_ok && mem_grant) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (mem_vld && mem_fin) begin
               addr_d  = addr_q + ADDR_W'(blen_q) * WORD_BYTES;
               state_d = (words_left_q != '0) ? ST_CALC : ST_WAIT_DRAIN;
            end
         end
         ST_WAIT_DRAIN: begin
            // The equality term covers a zero-element job, which has nothing to accept.
            if ((emitted_q == elems_q) || (accept && last_elem)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         elems_q      <= '0;
         words_left_q <= '0;
         emitted_q    <= '0;
         blen_q       <= '0;
         addr_q       <= '0;
         slice_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         elems_q      <= elems_d;
         words_left_q <= words_left_d;
         emitted_q    <= emitted_d;
         blen_q       <= blen_d;
         addr_q       <= addr_d;
         slice_q      <= slice_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         done_q       <= done_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= mem_din;
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = done_q;
      ccm_req  = (state_q == ST_REQ) && req_ok;
      mem_cmd  = ccm_req ? 4'(blen_q - BLEN_W'(1)) : '0;
      mem_addr = addr_q;
      kern_vld = vld;
      kern_out = vld ? head_elem : '0;
   end

endmodule

// File: tb/tb_kern_burst_reader.sv
// tb_kern_burst_reader
//   Directed bench for kern_burst_reader (default parameters). A memory model
//   returns, for byte address a, the word {a/2+1, a/2}, so element e of a job
//   based at B must read B/2+e.
module tb_kern_burst_reader;

   logic        clk;
   logic        rst_n;
   logic        op_start;
   logic [31:0] cfg_kern_start_addr;
   logic [9:0]  cfg_num_fmap;
   logic [9:0]  cfg_num_kern;
   logic [2:0]  cfg_kern_size;
   logic        busy;
   logic        done;
   logic        ccm_req;
   logic        mem_grant;
   logic [31:0] mem_addr;
   logic [3:0]  mem_cmd;
   logic [31:0] mem_din;
   logic        mem_vld;
   logic        mem_fin;
   logic [15:0] kern_out;
   logic        kern_vld;
   logic        kern_rdy;

   kern_burst_reader #(
      .MEM_DW(32), .ELEM_W(16), .ADDR_W(32), .MAX_BURST(16), .FIFO_WORDS(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .op_start(op_start),
      .cfg_kern_start_addr(cfg_kern_start_addr), .cfg_num_fmap(cfg_num_fmap),
      .cfg_num_kern(cfg_num_kern), .cfg_kern_size(cfg_kern_size),
      .busy(busy), .done(done), .ccm_req(ccm_req), .mem_grant(mem_grant),
      .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_din(mem_din), .mem_vld(mem_vld),
      .mem_fin(mem_fin), .kern_out(kern_out), .kern_vld(kern_vld), .kern_rdy(kern_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   bit          mon_en = 1'b0;
   int          rdy_mode = 0;
   int          grant_delay = 0;
   int unsigned exp_elems = 0;
   int unsigned hs_cnt = 0;
   int unsigned words_rx = 0;
   int unsigned popped = 0;
   logic [15:0] exp_first = '0;
   bit          last_logged = 1'b0;
   bit          done_seen = 1'b0;
   bit          stall_prev = 1'b0;
   logic [15:0] stall_val = '0;
   logic [31:0] burst_addr[$];
   logic [3:0]  burst_cmd[$];
   int          mphase = 0;
   int          mrem = 0;
   int          mwait = 0;
   bit          mfirst = 1'b0;
   logic [31:0] maddr = '0;

   // Monitor first (sees state after the last posedge), then memory drive.
   initial begin
      mem_grant = 1'b0; mem_vld = 1'b0; mem_fin = 1'b0; mem_din = '0; kern_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_grant = 1'b0; mem_vld = 1'b0; mem_fin = 1'b0;
            mphase = 0; mwait = 0; last_logged = 1'b0; stall_prev = 1'b0;
         end else begin
            if (mem_vld) words_rx++;
            if (mon_en) begin
               popped = (hs_cnt == exp_elems) ? (hs_cnt + 1) / 2 : hs_cnt / 2;
               chk("kern_vld", 32'(kern_vld), 32'((words_rx > popped) && (hs_cnt < exp_elems)));
               if (ccm_req)
                  chk("req_space", 32'((32 - (words_rx - popped)) >= (32'(mem_cmd) + 1)), 32'd1);
               if (last_logged) begin
                  chk("done", 32'(done), 32'd1);
                  chk("busy_at_done", 32'(busy), 32'd0);
                  done_seen   = 1'b1;
                  last_logged = 1'b0;
               end else if (done) begin
                  chk("done_spurious", 32'(done), 32'd0);
               end
               if (stall_prev) begin
                  chk("stall_vld", 32'(kern_vld), 32'd1);
                  chk("stall_out", 32'(kern_out), 32'(stall_val));
               end
               kern_rdy   = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
               stall_prev = kern_vld && !kern_rdy;
               stall_val  = kern_out;
               if (kern_vld && kern_rdy) begin
                  chk("elem", 32'(kern_out), 32'(16'(exp_first + hs_cnt)));
                  hs_cnt++;
                  if (hs_cnt == exp_elems) last_logged = 1'b1;
               end
            end
            if (mphase == 1) begin
               mem_grant = 1'b0;
               if (mfirst && mon_en) chk("req_drop", 32'(ccm_req), 32'd0);
               mfirst = 1'b0;
               if (mrem > 0) begin
                  mem_vld = 1'b1;
                  mem_din = {16'(maddr[16:1] + 16'd1), maddr[16:1]};
                  mem_fin = (mrem == 1);
                  maddr   = maddr + 32'd4;
                  mrem--;
               end else begin
                  mem_vld = 1'b0; mem_fin = 1'b0; mphase = 0;
               end
            end
            if (mphase == 0) begin
               mem_vld = 1'b0; mem_fin = 1'b0;
               if (ccm_req && (mwait >= grant_delay)) begin
                  mem_grant = 1'b1;
                  burst_addr.push_back(mem_addr);
                  burst_cmd.push_back(mem_cmd);
                  mrem = int'(mem_cmd) + 1; maddr = mem_addr;
                  mphase = 1; mwait = 0; mfirst = 1'b1;
               end else begin
                  mem_grant = 1'b0;
                  if (ccm_req) mwait++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic start_op(input int f, input int k, input int ks, input logic [31:0] base,
                           input int mode, input int gd, input int unsigned elems);
      rdy_mode = mode; grant_delay = gd; exp_elems = elems; exp_first = base[16:1];
      hs_cnt = 0; words_rx = 0; done_seen = 1'b0; last_logged = 1'b0; stall_prev = 1'b0;
      burst_addr.delete(); burst_cmd.delete();
      cfg_num_fmap = 10'(f); cfg_num_kern = 10'(k); cfg_kern_size = 3'(ks);
      cfg_kern_start_addr = base;
      mon_en = 1'b1;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
      chk("busy_start", 32'(busy), 32'd1);
   endtask

   task automatic finish_op(input int nb, input int words, input logic [31:0] base);
      for (int i = 0; i < 20000 && !done_seen; i++) tick();
      chk("done_seen", 32'(done_seen), 32'd1);
      chk("elem_count", hs_cnt, exp_elems);
      chk("burst_count", burst_addr.size(), nb);
      for (int i = 0; i < burst_addr.size() && i < nb; i++) begin
         chk("burst_addr", burst_addr[i], base + 32'(64 * i));
         chk("burst_cmd", 32'(burst_cmd[i]), (i == nb - 1) ? 32'(words - 16 * (nb - 1) - 1) : 32'd15);
      end
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_vld", 32'(kern_vld), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_req"}, 32'(ccm_req), 32'd0);
      chk({tag, "_cmd"}, 32'(mem_cmd), 32'd0);
      chk({tag, "_addr"}, mem_addr, 32'd0);
      chk({tag, "_vld"}, 32'(kern_vld), 32'd0);
      chk({tag, "_out"}, 32'(kern_out), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; op_start = 1'b0;
      cfg_kern_start_addr = '0; cfg_num_fmap = '0; cfg_num_kern = '0; cfg_kern_size = '0;
      tick();
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // 1x1x3: 10 elements, 5 words, one burst of 5
      start_op(1, 1, 3, 32'h0000_0100, 0, 0, 10);
      finish_op(1, 5, 32'h0000_0100);

      // 4x8x3: 296 elements, 148 words, 9x16 + 1x4; op_start while busy is ignored
      start_op(4, 8, 3, 32'h0000_1000, 0, 0, 296);
      for (int i = 0; i < 5; i++) tick();
      cfg_num_fmap = 10'd1; cfg_num_kern = 10'd1; cfg_kern_size = 3'd1;
      cfg_kern_start_addr = 32'h0000_F000;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
      finish_op(10, 148, 32'h0000_1000);

      // odd/short totals
      start_op(1, 1, 1, 32'h0000_0200, 0, 0, 2);
      finish_op(1, 1, 32'h0000_0200);
      start_op(1, 3, 1, 32'h0000_0300, 0, 0, 6);
      finish_op(1, 3, 32'h0000_0300);
      start_op(1, 1, 2, 32'h0000_0400, 0, 0, 5);
      finish_op(1, 3, 32'h0000_0400);

      // sparse consumer: stalls, FIFO fills, request withheld
      start_op(4, 8, 3, 32'h0000_3000, 1, 0, 296);
      finish_op(10, 148, 32'h0000_3000);

      // grant delayed 20 cycles per burst
      start_op(4, 8, 3, 32'h0000_8000, 0, 20, 296);
      finish_op(10, 148, 32'h0000_8000);

      // reset in the middle of a burst, then a clean job
      start_op(4, 8, 3, 32'h0000_2000, 0, 0, 296);
      for (int i = 0; i < 2000 && !(burst_addr.size() >= 2 && mphase == 1 && mrem < 12); i++) tick();
      chk("reached_data", 32'(burst_addr.size() >= 2 && mphase == 1), 32'd1);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_vld", 32'(kern_vld), 32'd0);
      start_op(1, 1, 3, 32'h0000_0600, 0, 0, 10);
      finish_op(1, 5, 32'h0000_0600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
